intersection_phase_scheduler: RTL

//   Sequences the two light groups (NS, EW) of one intersection.

---
 rtl/tl_pkg.sv | 50 +++++
 rtl/tl_phase_timer.sv | 35 +++
 rtl/intersection_phase_scheduler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Purpose : shared types for the intersection phase scheduler.
//   light_t  - 2-bit lamp code driven to the light output drivers
//   phase_e  - scheduler phase (FSM state)
//   ns_light / ew_light - lamp codes shown by each light group in a phase
// Ports   : none (package).
package tl_pkg;

  typedef enum logic [1:0] {
    L_RED    = 2'b00,
    L_GREEN  = 2'b01,
    L_YELLOW = 2'b10,
    L_FLASH  = 2'b11
  } light_t;

  typedef enum logic [2:0] {
    ALLRED_A  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_B  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    PED_WALK  = 3'd6,
    NIGHT     = 3'd7
  } phase_e;

  function automatic light_t ns_light(input phase_e p);
    light_t l;
    l = L_RED;
    case (p)
      NS_GREEN:  l = L_GREEN;
      NS_YELLOW: l = L_YELLOW;
      NIGHT:     l = L_FLASH;
      default:   l = L_RED;
    endcase
    return l;
  endfunction

  function automatic light_t ew_light(input phase_e p);
    light_t l;
    l = L_RED;
    case (p)
      EW_GREEN:  l = L_GREEN;
      EW_YELLOW: l = L_YELLOW;
      NIGHT:     l = L_FLASH;
      default:   l = L_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Purpose : loadable down-counter timing the current phase. Load has
//   priority over decrement; the count saturates at zero (never wraps).
// Ports   :
//   clk, reset  clock, asynchronous active-high reset (count <= RST_VAL)
//   load        load load_val on the next edge
//   en          decrement by one on the next edge when count is non-zero
//   load_val    value to load
//   count       current count
//   zero        count == 0
module tl_phase_timer #(
  parameter int              CNT_W   = 32,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Purpose : sequences the NS and EW light groups of one intersection,
//   arbitrating latched vehicle requests, the pedestrian button and night
//   (flashing) operation. All outputs are registered.
// Optional feature: define PED_WALK_EN to enable the pedestrian walk phase;
//   without it the button is ignored and walk is tied low.
// Ports   :
//   clk, reset          clock, asynchronous active-high reset
//   req_ns, req_ew      vehicle detects (latched until own green is entered)
//   switch              pedestrian button (latched)
//   night_mode          request flashing-yellow operation
//   out, out2           NS / EW lamp codes (00 red, 01 green, 10 yellow, 11 flash)
//   counter, counter2   cycles remaining in the current phase (0 in NIGHT)
//   walk                pedestrian walk lamp
// Handshake: none; request inputs are sticky-latched, so a one-cycle pulse
//   is as good as a held level.
module intersection_phase_scheduler
  import tl_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_ns,
  input  logic             req_ew,
  input  logic             switch,
  input  logic             night_mode,
  output logic [1:0]       out,
  output logic [1:0]       out2,
  output logic [CNT_W-1:0] counter,
  output logic [CNT_W-1:0] counter2,
  output logic             walk
);

  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(WALK_T - 1);
  // Counter at or below this value means GREEN_MIN cycles have been served.
  localparam logic [CNT_W-1:0] EARLY_TH  = CNT_W'(GREEN_MAX - GREEN_MIN);

  phase_e           state, nxt;
  logic             pend_ns, pend_ew;
  logic             ped_pend, ped_to_ew;
  logic             t_load, t_en, t_zero;
  logic [CNT_W-1:0] t_load_val, t_count;
  logic             early_ok;

  tl_phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_ALLRED)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .en       (t_en),
    .load_val (t_load_val),
    .count    (t_count),
    .zero     (t_zero)
  );

  assign counter  = t_count;
  assign counter2 = t_count;
  assign t_en     = (state != NIGHT);
  assign early_ok = (t_count <= EARLY_TH);

  // Next phase and timer reload; the timer is reloaded on every phase change.
  always_comb begin
    nxt        = state;
    t_load     = 1'b0;
    t_load_val = '0;
    case (state)
      ALLRED_A, ALLRED_B: begin
        if (t_zero) begin
          t_load = 1'b1;
          if (night_mode) begin
            nxt        = NIGHT;
            t_load_val = '0;
          end else if (ped_pend) begin
            nxt        = PED_WALK;
            t_load_val = LD_WALK;
          end else begin
            nxt        = (state == ALLRED_A) ? NS_GREEN : EW_GREEN;
            t_load_val = LD_GREEN;
          end
        end
      end
      NS_GREEN: begin
        if (t_zero || (early_ok && (pend_ew || ped_pend))) begin
          nxt        = NS_YELLOW;
          t_load     = 1'b1;
          t_load_val = LD_YELLOW;
        end
      end
      NS_YELLOW: begin
        if (t_zero) begin
          nxt        = ALLRED_B;
          t_load     = 1'b1;
          t_load_val = LD_ALLRED;
        end
      end
      EW_GREEN: begin
        if (t_zero || (early_ok && (pend_ns || ped_pend))) begin
          nxt        = EW_YELLOW;
          t_load     = 1'b1;
          t_load_val = LD_YELLOW;
        end
      end
      EW_YELLOW: begin
        if (t_zero) begin
          nxt        = ALLRED_A;
          t_load     = 1'b1;
          t_load_val = LD_ALLRED;
        end
      end
      PED_WALK: begin
        if (t_zero) begin
          nxt        = ped_to_ew ? EW_GREEN : NS_GREEN;
          t_load     = 1'b1;
          t_load_val = LD_GREEN;
        end
      end
      NIGHT: begin
        if (!night_mode) begin
          nxt        = ALLRED_A;
          t_load     = 1'b1;
          t_load_val = LD_ALLRED;
        end
      end
      default: begin
        nxt        = ALLRED_A;
        t_load     = 1'b1;
        t_load_val = LD_ALLRED;
      end
    endcase
  end

`ifdef PED_WALK_EN
  logic pend_ped;
  logic ped_dir_q;
  assign ped_pend  = pend_ped;
  assign ped_to_ew = ped_dir_q;
`else
  logic unused_switch;
  assign unused_switch = switch;
  assign ped_pend      = 1'b0;
  assign ped_to_ew     = 1'b0;
  assign walk          = 1'b0;
`endif

  // State, registered lamp outputs and pending flags. A request arriving on
  // the edge that enters its own green is absorbed (clear wins).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ALLRED_A;
      out     <= L_RED;
      out2    <= L_RED;
      pend_ns <= 1'b0;
      pend_ew <= 1'b0;
`ifdef PED_WALK_EN
      pend_ped  <= 1'b0;
      ped_dir_q <= 1'b0;
      walk      <= 1'b0;
`endif
    end else begin
      state   <= nxt;
      out     <= ns_light(nxt);
      out2    <= ew_light(nxt);
      pend_ns <= ((nxt == NS_GREEN) && (state != NS_GREEN)) ? 1'b0 : (pend_ns | req_ns);
      pend_ew <= ((nxt == EW_GREEN) && (state != EW_GREEN)) ? 1'b0 : (pend_ew | req_ew);
`ifdef PED_WALK_EN
      pend_ped <= ((nxt == PED_WALK) && (state != PED_WALK)) ? 1'b0 : (pend_ped | switch);
      // Remember which green the interrupted ALLRED was heading for.
      if ((nxt == PED_WALK) && (state != PED_WALK)) begin
        ped_dir_q <= (state == ALLRED_B);
      end
      walk <= (nxt == PED_WALK);
`endif
    end
  end

endmodule
